// File: rtl/cdda_play_ctrl.sv
// CD-DA playback sequencer: fetches sectors from the image reader and streams words into the sample FIFO.
// Define CDDA_REPEAT_EN to add the REPEAT input, which loops the LBA range instead of finishing.
module cdda_play_ctrl #(
   parameter int unsigned SECTOR_WORDS = 1176,
   parameter int unsigned LBA_WIDTH    = 20
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 CMD_PLAY,
   input  logic                 CMD_PAUSE,
   input  logic                 CMD_RESUME,
   input  logic                 CMD_STOP,
   input  logic [LBA_WIDTH-1:0] START_LBA,
   input  logic [LBA_WIDTH-1:0] END_LBA,
   input  logic                 FIFO_REQ,
   output logic                 SECTOR_REQ,
   output logic [LBA_WIDTH-1:0] SECTOR_LBA,
   input  logic                 SECTOR_ACK,
   output logic                 SECTOR_ABORT,
   input  logic                 DATA_VALID,
   input  logic [15:0]          DATA_IN,
`ifdef CDDA_REPEAT_EN
   input  logic                 REPEAT,
`endif
   output logic                 DATA_READY,
   output logic                 WRITE,
   output logic [15:0]          DOUT,
   output logic                 PLAYING,
   output logic                 PAUSED,
   output logic                 DONE,
   output logic [LBA_WIDTH-1:0] CUR_LBA
);

   localparam int unsigned CW = $clog2(SECTOR_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SPACE,
      S_REQ,
      S_XFER,
      S_PAUSED
   } state_t;

   state_t               state_q, state_d;
   logic [LBA_WIDTH-1:0] start_q, start_d, end_q, end_d;
   logic [LBA_WIDTH:0]   cur_q, cur_d;   // extra MSB records a wrap past all-ones for the end check
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 write_q, write_d;
   logic [15:0]          dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 abort_q, abort_d;
   logic                 pause_pend_q, pause_pend_d;
   logic                 stop_pend_q, stop_pend_d;
   logic                 restart_q, restart_d;

   logic                 repeat_w;
   logic                 play_cmd, stop_eff, restart_eff, ready, past_end, go_restart;
   logic [LBA_WIDTH-1:0] rs, re;

`ifdef CDDA_REPEAT_EN
   assign repeat_w = REPEAT;
`else
   assign repeat_w = 1'b0;
`endif

   // A PLAY while active behaves as a STOP plus restart, so it also triggers the even-count stop point.
   always_comb begin
      play_cmd    = CMD_PLAY & ~CMD_STOP;
      stop_eff    = stop_pend_q | CMD_STOP | CMD_PLAY;
      restart_eff = ~CMD_STOP & (CMD_PLAY | restart_q);
      ready       = (state_q == S_XFER) && !write_q && (cnt_q < CW'(SECTOR_WORDS))
                    && !(stop_eff && !cnt_q[0]);
      past_end    = cur_q > {1'b0, end_q};
      rs          = play_cmd ? START_LBA : start_q;
      re          = play_cmd ? END_LBA   : end_q;
   end

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      end_d        = end_q;
      cur_d        = cur_q;
      cnt_d        = cnt_q;
      write_d      = 1'b0;
      dout_d       = dout_q;
      done_d       = done_q;
      abort_d      = 1'b0;
      pause_pend_d = pause_pend_q;
      stop_pend_d  = stop_pend_q;
      restart_d    = restart_q;
      go_restart   = 1'b0;

      if (play_cmd) begin
         start_d = START_LBA;
         end_d   = END_LBA;
         done_d  = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (play_cmd) go_restart = 1'b1;
         end
         S_WAIT_SPACE: begin
            if (CMD_STOP) begin
               state_d = S_IDLE;
            end else if (play_cmd) begin
               go_restart = 1'b1;
            end else if (past_end) begin
               if (repeat_w) begin
                  cur_d = {1'b0, start_q};
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (pause_pend_q || CMD_PAUSE) begin
               state_d = S_PAUSED;
            end else if (FIFO_REQ) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (CMD_STOP || play_cmd) begin
               abort_d = 1'b1;
               if (play_cmd) go_restart = 1'b1;
               else          state_d    = S_IDLE;
            end else begin
               if (CMD_PAUSE) pause_pend_d = 1'b1;
               if (SECTOR_ACK) begin
                  cnt_d   = '0;
                  state_d = S_XFER;
               end
            end
         end
         S_XFER: begin
            if (ready && DATA_VALID) begin
               write_d = 1'b1;
               dout_d  = DATA_IN;
               cnt_d   = cnt_q + 1'b1;
            end
            if (stop_eff && !write_q && !cnt_q[0]) begin
               abort_d = 1'b1;
               if (restart_eff) go_restart = 1'b1;
               else             state_d    = S_IDLE;
            end else begin
               if (stop_eff) begin
                  stop_pend_d = 1'b1;
                  restart_d   = restart_eff;
               end else if (CMD_PAUSE) begin
                  pause_pend_d = 1'b1;
               end
               if (!write_q && cnt_q == CW'(SECTOR_WORDS)) begin
                  cur_d   = cur_q + 1'b1;
                  state_d = S_WAIT_SPACE;
               end
            end
         end
         S_PAUSED: begin
            if (CMD_STOP)                    state_d    = S_IDLE;
            else if (play_cmd)               go_restart = 1'b1;
            else if (CMD_RESUME && !CMD_PAUSE) state_d  = S_WAIT_SPACE;
         end
         default: state_d = S_IDLE;
      endcase

      if (go_restart) begin
         cur_d        = {1'b0, rs};
         pause_pend_d = 1'b0;
         stop_pend_d  = 1'b0;
         restart_d    = 1'b0;
         if (rs > re) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end else begin
            state_d = S_WAIT_SPACE;
         end
      end

      if (state_d == S_IDLE || state_d == S_PAUSED) begin
         pause_pend_d = 1'b0;
         stop_pend_d  = 1'b0;
         restart_d    = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         start_q      <= '0;
         end_q        <= '0;
         cur_q        <= '0;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         dout_q       <= '0;
         done_q       <= 1'b0;
         abort_q      <= 1'b0;
         pause_pend_q <= 1'b0;
         stop_pend_q  <= 1'b0;
         restart_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         end_q        <= end_d;
         cur_q        <= cur_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         dout_q       <= dout_d;
         done_q       <= done_d;
         abort_q      <= abort_d;
         pause_pend_q <= pause_pend_d;
         stop_pend_q  <= stop_pend_d;
         restart_q    <= restart_d;
      end
   end

   assign SECTOR_REQ   = (state_q == S_REQ);
   assign SECTOR_LBA   = cur_q[LBA_WIDTH-1:0];
   assign CUR_LBA      = cur_q[LBA_WIDTH-1:0];
   assign SECTOR_ABORT = abort_q;
   assign DATA_READY   = ready;
   assign WRITE        = write_q;
   assign DOUT         = dout_q;
   assign PLAYING      = (state_q == S_WAIT_SPACE) || (state_q == S_REQ) || (state_q == S_XFER);
   assign PAUSED       = (state_q == S_PAUSED);
   assign DONE         = done_q;

endmodule

// File: tb/tb_cdda_play_ctrl.sv
// Bench for cdda_play_ctrl: random reader/FIFO behaviour checked against sector lists and word streams.
// Build with CDDA_REPEAT_EN defined to also exercise the REPEAT input.
module tb_cdda_play_ctrl;
   localparam int unsigned SW = 1176;
   localparam int unsigned LW = 20;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          CMD_PLAY, CMD_PAUSE, CMD_RESUME, CMD_STOP;
   logic [LW-1:0] START_LBA, END_LBA;
   logic          FIFO_REQ, SECTOR_REQ, SECTOR_ACK, SECTOR_ABORT;
   logic [LW-1:0] SECTOR_LBA, CUR_LBA;
   logic          DATA_VALID, DATA_READY, WRITE;
   logic [15:0]   DATA_IN, DOUT;
   logic          PLAYING, PAUSED, DONE;
`ifdef CDDA_REPEAT_EN
   logic          REPEAT;
`endif

   int checks   = 0;
   int failures = 0;

   logic [LW-1:0] req_lbas[$];
   logic [15:0]   sent_q[$];
   logic [15:0]   got_q[$];
   int aborts     = 0;
   int viol       = 0;
   int req_cycles = 0;
   int valid_pct  = 100;
   int fifo_mode  = 1;   // 0 low, 1 high, 2 random
   bit prev_write = 1'b0;

   cdda_play_ctrl #(.SECTOR_WORDS(SW), .LBA_WIDTH(LW)) dut (
      .CLK(CLK), .RESET(RESET),
      .CMD_PLAY(CMD_PLAY), .CMD_PAUSE(CMD_PAUSE), .CMD_RESUME(CMD_RESUME), .CMD_STOP(CMD_STOP),
      .START_LBA(START_LBA), .END_LBA(END_LBA), .FIFO_REQ(FIFO_REQ),
      .SECTOR_REQ(SECTOR_REQ), .SECTOR_LBA(SECTOR_LBA), .SECTOR_ACK(SECTOR_ACK),
      .SECTOR_ABORT(SECTOR_ABORT), .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN),
`ifdef CDDA_REPEAT_EN
      .REPEAT(REPEAT),
`endif
      .DATA_READY(DATA_READY), .WRITE(WRITE), .DOUT(DOUT),
      .PLAYING(PLAYING), .PAUSED(PAUSED), .DONE(DONE), .CUR_LBA(CUR_LBA)
   );

   initial forever #5 CLK = ~CLK;

   // Reader and FIFO side: drive on negedge, observe just before the next posedge.
   initial begin : reader
      int ack_dly;
      bit ack_pend;
      ack_dly = 0; ack_pend = 1'b0;
      SECTOR_ACK = 1'b0; DATA_VALID = 1'b0; DATA_IN = '0; FIFO_REQ = 1'b0;
      forever begin
         @(negedge CLK);
         SECTOR_ACK = 1'b0;
         DATA_IN    = 16'($urandom);
         DATA_VALID = ($urandom_range(0, 99) < valid_pct);
         case (fifo_mode)
            0:       FIFO_REQ = 1'b0;
            1:       FIFO_REQ = 1'b1;
            default: FIFO_REQ = ($urandom_range(0, 3) != 0);
         endcase
         if (!SECTOR_REQ) begin
            ack_pend = 1'b0;
         end else begin
            if (!ack_pend) begin
               ack_pend = 1'b1;
               ack_dly  = $urandom_range(0, 2);
            end
            if (ack_dly == 0) begin
               SECTOR_ACK = 1'b1;
               ack_pend   = 1'b0;
               req_lbas.push_back(SECTOR_LBA);
            end else begin
               ack_dly--;
            end
         end
         #4;
         if (DATA_READY && DATA_VALID) sent_q.push_back(DATA_IN);
         if (WRITE) begin
            got_q.push_back(DOUT);
            if (prev_write) viol++;
         end
         prev_write = WRITE;
         if (SECTOR_ABORT) aborts++;
         if (SECTOR_REQ) req_cycles++;
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog observed=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic clear_log();
      req_lbas.delete(); sent_q.delete(); got_q.delete();
      aborts = 0; viol = 0; req_cycles = 0;
   endtask

   task automatic play(input logic [LW-1:0] s, input logic [LW-1:0] e);
      START_LBA = s; END_LBA = e; CMD_PLAY = 1'b1;
      @(negedge CLK);
      CMD_PLAY = 1'b0;
   endtask

   task automatic pulse_pause();
      CMD_PAUSE = 1'b1; @(negedge CLK); CMD_PAUSE = 1'b0;
   endtask

   task automatic pulse_resume();
      CMD_RESUME = 1'b1; @(negedge CLK); CMD_RESUME = 1'b0;
   endtask

   task automatic pulse_stop();
      CMD_STOP = 1'b1; @(negedge CLK); CMD_STOP = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int c = 0;
      while (!DONE && c < budget) begin @(negedge CLK); c++; end
      chk(tag, DONE, 1);
   endtask

   task automatic wait_sent(input int n, input int budget, input string tag);
      int c = 0;
      while (sent_q.size() < n && c < budget) begin @(negedge CLK); c++; end
      chk(tag, sent_q.size(), n);
   endtask

   task automatic wait_reqs(input int n, input int budget, input string tag);
      int c = 0;
      while (req_lbas.size() < n && c < budget) begin @(negedge CLK); c++; end
      chk(tag, req_lbas.size(), n);
   endtask

   task automatic wait_paused(input int budget, input string tag);
      int c = 0;
      while (!PAUSED && c < budget) begin @(negedge CLK); c++; end
      chk(tag, PAUSED, 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int c = 0;
      while (PLAYING && c < budget) begin @(negedge CLK); c++; end
      chk(tag, PLAYING, 0);
   endtask

   // Expected sectors: consecutive LBAs from s, modulo 2^LW.
   task automatic chk_lbas(input string tag, input logic [LW-1:0] s, input int n);
      logic [LW-1:0] e;
      chk({tag, "_nreq"}, req_lbas.size(), n);
      for (int i = 0; i < n && i < req_lbas.size(); i++) begin
         e = LW'(s + LW'(i));
         chk({tag, "_lba"}, req_lbas[i], e);
      end
   endtask

   // Every word the reader handed over must reach the FIFO, in order, as isolated strobes.
   task automatic chk_stream(input string tag, input int words);
      int bad = 0;
      for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
         if (got_q[i] !== sent_q[i]) bad++;
      chk({tag, "_writes"}, got_q.size(), words);
      chk({tag, "_accepts"}, sent_q.size(), words);
      chk({tag, "_data_bad"}, bad, 0);
      chk({tag, "_back2back"}, viol, 0);
   endtask

   initial begin : main
      logic [LW-1:0] s;
      int len;
      RESET = 1'b1;
      CMD_PLAY = 1'b0; CMD_PAUSE = 1'b0; CMD_RESUME = 1'b0; CMD_STOP = 1'b0;
      START_LBA = '0; END_LBA = '0;
`ifdef CDDA_REPEAT_EN
      REPEAT = 1'b0;
`endif
      settle(3);
      chk("rst_flags", {SECTOR_REQ, SECTOR_ABORT, DATA_READY, WRITE, PLAYING, PAUSED, DONE}, 0);
      chk("rst_dout", DOUT, 0);
      chk("rst_cur_lba", CUR_LBA, 0);
      chk("rst_sector_lba", SECTOR_LBA, 0);
      RESET = 1'b0;
      settle(2);

      // Two-sector play with an always-valid reader.
      clear_log();
      valid_pct = 100; fifo_mode = 1;
      play(100, 101);
      wait_done(8000, "t1_done");
      chk("t1_playing", PLAYING, 0);
      chk("t1_cur_lba", CUR_LBA, 102);
      chk("t1_aborts", aborts, 0);
      chk_lbas("t1", 100, 2);
      chk_stream("t1", 2 * SW);

      // No FIFO room: no request until FIFO_REQ rises.
      fifo_mode = 0; settle(2);
      clear_log();
      play(300, 300);
      settle(20);
      chk("t2_no_req", req_cycles, 0);
      chk("t2_playing", PLAYING, 1);
      fifo_mode = 1;
      begin
         bit seen = 1'b0;
         repeat (3) begin @(negedge CLK); #1; if (SECTOR_REQ) seen = 1'b1; end
      chk("t2_req_rise", seen, 1);
      end
      wait_done(6000, "t2_done");
      chk_lbas("t2", 300, 1);
      chk_stream("t2", SW);

      // Pause mid-sector, then resume, then stop after 7 words of the next sector.
      clear_log();
      valid_pct = 75;
      play(200, 210);
      wait_sent(500, 6000, "t3_word500");
      pulse_pause();
      wait_paused(6000, "t3_paused");
      chk("t3_cur_lba", CUR_LBA, 201);
      chk_stream("t3", SW);
      settle(30);
      chk("t3_no_new_req", req_lbas.size(), 1);
      chk("t3_still_paused", PAUSED, 1);
      pulse_resume();
      wait_reqs(2, 20, "t3_resume_req");
      chk_lbas("t3r", 200, 2);
      wait_sent(SW + 7, 200, "t4_word7");
      pulse_stop();
      wait_idle(50, "t4_idle");
      settle(3);
      chk("t4_aborts", aborts, 1);
      chk("t4_done", DONE, 0);
      chk("t4_paused", PAUSED, 0);
      chk_stream("t4", SW + 8);

      // PLAY while transferring: aligned stop, abort, immediate restart on the new range.
      clear_log();
      valid_pct = 100;
      play(500, 505);
      wait_sent(3, 50, "t5_word3");
      play(600, 600);
      wait_done(6000, "t5_done");
      chk("t5_nreq", req_lbas.size(), 2);
      chk("t5_lba0", req_lbas[0], 500);
      chk("t5_lba1", req_lbas[1], 600);
      chk("t5_aborts", aborts, 1);
      chk("t5_cur_lba", CUR_LBA, 601);
      chk_stream("t5", 4 + SW);

      // STOP and PLAY together: stop wins and the new range is ignored.
      fifo_mode = 0; settle(2);
      clear_log();
      play(400, 400);
      settle(2);
      chk("t6_playing", PLAYING, 1);
      START_LBA = 50; END_LBA = 60; CMD_STOP = 1'b1; CMD_PLAY = 1'b1;
      @(negedge CLK);
      CMD_STOP = 1'b0; CMD_PLAY = 1'b0;
      chk("t6_idle", PLAYING, 0);
      chk("t6_done", DONE, 0);
      chk("t6_cur_lba", CUR_LBA, 400);
      fifo_mode = 1;
      settle(5);
      chk("t6_no_req", req_lbas.size(), 0);

      // Empty range finishes immediately.
      play(20, 10);
      settle(1);
      chk("t7_done", DONE, 1);
      chk("t7_playing", PLAYING, 0);
      settle(5);
      chk("t7_no_req", req_lbas.size(), 0);

      // Last LBA of the address space: one sector, then wrap and finish.
      clear_log();
      s = '1;
      play(s, s);
      wait_done(6000, "t8_done");
      chk_lbas("t8", s, 1);
      chk("t8_cur_lba", CUR_LBA, 0);
      chk_stream("t8", SW);

      // Random ranges, reader pacing and FIFO room.
      for (int it = 0; it < 2; it++) begin
         clear_log();
         s = LW'($urandom_range(0, (1 << LW) - 4));
         len = $urandom_range(1, 2);
         valid_pct = $urandom_range(50, 100);
         fifo_mode = 2;
         play(s, LW'(s + LW'(len - 1)));
         wait_done(len * SW * 8 + 500, "rnd_done");
         chk("rnd_cur_lba", CUR_LBA, LW'(s + LW'(len)));
         chk_lbas("rnd", s, len);
         chk_stream("rnd", len * SW);
      end
      fifo_mode = 1; valid_pct = 100;

`ifdef CDDA_REPEAT_EN
      clear_log();
      REPEAT = 1'b1;
      play(5, 5);
      wait_reqs(3, 8000, "rep_reqs");
      chk("rep_done", DONE, 0);
      REPEAT = 1'b0;
      wait_done(8000, "rep_end_done");
      for (int i = 0; i < req_lbas.size(); i++) chk("rep_lba", req_lbas[i], 5);
      chk_stream("rep", req_lbas.size() * SW);
`endif

      // Reset mid-transfer: back to reset values with no abort pulse.
      clear_log();
      play(700, 701);
      wait_sent(10, 100, "rst_mid_words");
      RESET = 1'b1;
      settle(2);
      chk("rst_mid_aborts", aborts, 0);
      chk("rst_mid_flags", {SECTOR_REQ, SECTOR_ABORT, WRITE, PLAYING, PAUSED, DONE}, 0);
      chk("rst_mid_cur", CUR_LBA, 0);
      chk("rst_mid_dout", DOUT, 0);
      RESET = 1'b0;
      settle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
